lsu_ctrl_pipe: RTL
==================

// Module: lsu_ctrl_pipe
// PURPOSE
//  Parametrised multi-lane, multi-stage control pipeline for the LSU EX->WB path.
//  - Carries per-lane load/size/rd control bundles alongside the memory access.
//  - Adds real stall-hold, flush-to-bubble and NOP canonicalisation.
//  - Exports an in-flight-load rd mask for hazard detection.
//  - Sits between LSU EX decode and register-file writeback, one lane per VLIW LSU slot.
// PARAMETERS
//  LANES   2   number of parallel LSU slots
//  STAGES  1   pipeline depth (latency in cycles), must be >= 1
//  RD_W    5   destination register index width
//  SIZE_W  2   access size code width (00=B, 01=H, 10=W)
//  CNT_W   32  width of performance counters (used only when LSU_PIPE_PERF_EN is defined)
// PORTS
//  clk               in   1             clock, all state on rising edge
//  rst               in   1             synchronous reset, active-high
//  stall             in   1             hold all stages
//  flush             in   1             kill all in-flight bundles
//  is_load_in        in   LANES         lane performs a load
//  zero_ext_in       in   LANES         zero-extend (1) / sign-extend (0) load data
//  is_nop_in         in   LANES         lane slot is a bubble
//  size_in           in   LANES*SIZE_W  access size per lane
//  rd_in             in   LANES*RD_W    destination register per lane
//  is_load_out       out  LANES         final stage, per lane
//  zero_ext_out      out  LANES         final stage, per lane
//  is_nop_out        out  LANES         final stage, per lane
//  size_out          out  LANES*SIZE_W  final stage, per lane
//  rd_out            out  LANES*RD_W    final stage, per lane
//  load_pend_mask    out  2**RD_W       bit r set if any stage holds non-NOP load with rd==r, r!=0
//  stall_cycles      out  CNT_W         [LSU_PIPE_PERF_EN only] cycles with stall=1
//  loads_retired     out  CNT_W         [LSU_PIPE_PERF_EN only] loads leaving final stage
// BEHAVIOUR
//  - Priority per cycle: rst > flush > stall > advance.
//  - Reset: every stage, every lane = bubble:
//    - is_nop=1; is_load=0, zero_ext=0, size=0, rd=0.
//    - Hence all *_out at bubble values, load_pend_mask=0, counters=0.
//  - Advance (no stall/flush):
//    - stage0 <= canonicalised inputs; stage k <= stage k-1.
//    - Outputs = stage STAGES-1, so latency is exactly STAGES cycles.
//  - Canonicalise on capture: is_nop_in=1 forces is_load=0, zero_ext=0, size=0, rd=0 for that lane.
//  - Stall: all stages hold; inputs ignored (upstream must hold them); outputs stable.
//  - Flush: all stages become bubbles next cycle, including the input captured that cycle.
//    - Flush with stall: flush wins.
//  - load_pend_mask:
//    - Combinational OR over all stages/lanes of registered state only; no input path.
//    - rd==0 never sets a bit.
//    - Two lanes targeting the same rd set one bit; no error flagged.
//  - Lanes are independent; no cross-lane ordering or merging.
//  - Mid-operation reset: in-flight bundles discarded; first valid output appears STAGES cycles after
//    the first non-stalled capture following reset deassertion.
// CONFIGURATION
//  - LSU_PIPE_PERF_EN defined:
//    - stall_cycles increments each cycle rst=0 && stall=1 && flush=0.
//    - loads_retired increments by the count of final-stage lanes with is_load=1, on cycles that advance.
//    - Both saturate at all-ones; cleared only by rst.
//  - Not defined: counter ports and logic absent; no other behaviour changes.
// STRUCTURE
//  - lsu_pkg:
//    - typedef lsu_ctrl_t {is_load, zero_ext, is_nop, size[SIZE_W], rd[RD_W]}.
//    - Constant LSU_CTRL_NOP (bubble value); size enum LSU_SZ_B/H/W.
//  - Sub-module lsu_ctrl_stage: one stage of LANES lsu_ctrl_t with hold/flush/rst; generate-chained STAGES times.
//  - Top: canonicalisation, pend-mask reduction, optional counters, elaboration check STAGES>=1.
// TESTING
//  - Reset: rst=1 for 2 cycles -> is_nop_out='1, rd_out=0, load_pend_mask=0.
//  - Latency (STAGES=3, LANES=2):
//    - Drive lane0 load rd=7 size=10, lane1 nop for 1 cycle.
//    - Exactly 3 cycles later: is_load_out=01, rd_out lane0=7, size=10, is_nop_out=10.
//    - Mask bit7 set during cycles 1..3.
//  - Stall: stall=1 for 4 cycles mid-flight -> all outputs and mask frozen; resume -> remaining latency unchanged.
//  - Flush during stall:
//    - Stall and flush together with 3 loads in flight -> next cycle all bubbles, load_pend_mask=0.
//    - loads_retired not incremented.
//  - Canonicalisation: is_nop_in=1 with is_load_in=1, rd_in=9 -> output bubble with rd=0, mask bit9 never set.
//  - Perf (LSU_PIPE_PERF_EN, CNT_W=4):
//    - 20 stall cycles -> stall_cycles=15 (saturated).
//    - Two-lane load retire -> loads_retired +2.

Source files
------------

// File: rtl/lsu_ctrl_pipe_pkg.sv
// Shared control-bundle types for the LSU EX->WB control pipeline.
// Latency: n/a. Backpressure: n/a.
package lsu_pkg;

    localparam int LSU_RD_W   = 5;
    localparam int LSU_SIZE_W = 2;

    typedef enum logic [LSU_SIZE_W-1:0] {
        LSU_SZ_B = 2'b00,
        LSU_SZ_H = 2'b01,
        LSU_SZ_W = 2'b10
    } lsu_size_e;

    typedef struct packed {
        logic                  is_load;
        logic                  zero_ext;
        logic                  is_nop;
        logic [LSU_SIZE_W-1:0] size;
        logic [LSU_RD_W-1:0]   rd;
    } lsu_ctrl_t;

    localparam lsu_ctrl_t LSU_CTRL_NOP = '{is_load: 1'b0, zero_ext: 1'b0, is_nop: 1'b1,
                                           size: '0, rd: '0};

    // A bubble carries no side information, so downstream never sees stale rd/size.
    function automatic lsu_ctrl_t lsu_canon(input logic is_load, input logic zero_ext,
                                            input logic is_nop, input logic [LSU_SIZE_W-1:0] size,
                                            input logic [LSU_RD_W-1:0] rd);
        lsu_ctrl_t r;
        r = LSU_CTRL_NOP;
        if (!is_nop) begin
            r.is_load  = is_load;
            r.zero_ext = zero_ext;
            r.is_nop   = 1'b0;
            r.size     = size;
            r.rd       = rd;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_ctrl_pipe_if.sv
// Bundle of stall/flush, per-lane control inputs/outputs and the pend mask.
// Latency: n/a. Backpressure: stall from master holds the slave pipeline.
interface lsu_ctrl_pipe_if #(
    parameter int LANES  = 2,
    parameter int RD_W   = 5,
    parameter int SIZE_W = 2
`ifdef LSU_PIPE_PERF_EN
    , parameter int CNT_W = 32
`endif
);
    logic                     stall;
    logic                     flush;
    logic [LANES-1:0]         is_load_in;
    logic [LANES-1:0]         zero_ext_in;
    logic [LANES-1:0]         is_nop_in;
    logic [LANES*SIZE_W-1:0]  size_in;
    logic [LANES*RD_W-1:0]    rd_in;
    logic [LANES-1:0]         is_load_out;
    logic [LANES-1:0]         zero_ext_out;
    logic [LANES-1:0]         is_nop_out;
    logic [LANES*SIZE_W-1:0]  size_out;
    logic [LANES*RD_W-1:0]    rd_out;
    logic [2**RD_W-1:0]       load_pend_mask;
`ifdef LSU_PIPE_PERF_EN
    logic [CNT_W-1:0]         stall_cycles;
    logic [CNT_W-1:0]         loads_retired;

    modport master (output stall, flush, is_load_in, zero_ext_in, is_nop_in, size_in, rd_in,
                    input  is_load_out, zero_ext_out, is_nop_out, size_out, rd_out,
                           load_pend_mask, stall_cycles, loads_retired);
    modport slave  (input  stall, flush, is_load_in, zero_ext_in, is_nop_in, size_in, rd_in,
                    output is_load_out, zero_ext_out, is_nop_out, size_out, rd_out,
                           load_pend_mask, stall_cycles, loads_retired);
`else
    modport master (output stall, flush, is_load_in, zero_ext_in, is_nop_in, size_in, rd_in,
                    input  is_load_out, zero_ext_out, is_nop_out, size_out, rd_out,
                           load_pend_mask);
    modport slave  (input  stall, flush, is_load_in, zero_ext_in, is_nop_in, size_in, rd_in,
                    output is_load_out, zero_ext_out, is_nop_out, size_out, rd_out,
                           load_pend_mask);
`endif
endinterface

// File: rtl/lsu_ctrl_pipe_stage.sv
// One register stage of LANES control bundles; rst/flush load bubbles.
// Latency: 1 cycle. Backpressure: i_hold freezes contents (flush overrides).
module lsu_ctrl_stage
    import lsu_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_hold,
    input  logic                   i_flush,
    input  lsu_ctrl_t [LANES-1:0]  i_d,
    output lsu_ctrl_t [LANES-1:0]  o_q
);
    lsu_ctrl_t [LANES-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_q <= {LANES{LSU_CTRL_NOP}};
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/lsu_ctrl_pipe.sv
// Multi-lane LSU EX->WB control pipeline with in-flight load rd mask; LSU_PIPE_PERF_EN adds counters.
// Latency: STAGES cycles. Backpressure: stall holds every stage, flush turns all stages into bubbles.
module lsu_ctrl_pipe
    import lsu_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int STAGES = 1,
    parameter int RD_W   = 5,
    parameter int SIZE_W = 2
`ifdef LSU_PIPE_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    lsu_ctrl_pipe_if.slave  bus
);
    if (STAGES < 1) begin : g_bad_stages
        $error("lsu_ctrl_pipe: STAGES must be >= 1");
    end
    if (RD_W != LSU_RD_W || SIZE_W != LSU_SIZE_W) begin : g_bad_widths
        $error("lsu_ctrl_pipe: RD_W/SIZE_W must match lsu_pkg widths");
    end

    // w_pipe[0] is the canonicalised input, w_pipe[s+1] the output of stage s.
    lsu_ctrl_t [LANES-1:0] w_pipe [STAGES+1];
    lsu_ctrl_t [LANES-1:0] w_final;
    logic [2**RD_W-1:0]    w_mask;

    always_comb begin
        w_pipe[0] = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pipe[0][l] = lsu_canon(bus.is_load_in[l], bus.zero_ext_in[l], bus.is_nop_in[l],
                                     bus.size_in[l*SIZE_W +: SIZE_W], bus.rd_in[l*RD_W +: RD_W]);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        lsu_ctrl_stage #(.LANES(LANES)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_hold  (bus.stall),
            .i_flush (bus.flush),
            .i_d     (w_pipe[s]),
            .o_q     (w_pipe[s+1])
        );
    end

    assign w_final = w_pipe[STAGES];

    always_comb begin
        bus.is_load_out  = '0;
        bus.zero_ext_out = '0;
        bus.is_nop_out   = '0;
        bus.size_out     = '0;
        bus.rd_out       = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.is_load_out[l]                  = w_final[l].is_load;
            bus.zero_ext_out[l]                 = w_final[l].zero_ext;
            bus.is_nop_out[l]                   = w_final[l].is_nop;
            bus.size_out[l*SIZE_W +: SIZE_W]    = w_final[l].size;
            bus.rd_out[l*RD_W +: RD_W]          = w_final[l].rd;
        end
    end

    // Registered state only: x0 is never a hazard, duplicate rds simply merge.
    always_comb begin
        w_mask = '0;
        for (int s = 1; s <= STAGES; s++) begin
            for (int l = 0; l < LANES; l++) begin
                if (w_pipe[s][l].is_load && !w_pipe[s][l].is_nop && (w_pipe[s][l].rd != '0)) begin
                    w_mask[w_pipe[s][l].rd] = 1'b1;
                end
            end
        end
    end

    assign bus.load_pend_mask = w_mask;

`ifdef LSU_PIPE_PERF_EN
    localparam int NW = $clog2(LANES + 1);

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_loads_retired;
    logic [NW-1:0]    w_ret_n;
    logic [CNT_W:0]   w_ret_sum;
    logic             w_advance;

    assign w_advance = !bus.flush && !bus.stall;

    always_comb begin
        w_ret_n = '0;
        for (int l = 0; l < LANES; l++) begin
            if (w_final[l].is_load) begin
                w_ret_n = w_ret_n + 1'b1;
            end
        end
        w_ret_sum = {1'b0, r_loads_retired} + (CNT_W+1)'(w_ret_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_loads_retired <= '0;
        end else begin
            if (bus.stall && !bus.flush && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_advance) begin
                r_loads_retired <= w_ret_sum[CNT_W] ? '1 : w_ret_sum[CNT_W-1:0];
            end
        end
    end

    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.loads_retired = r_loads_retired;
`endif
endmodule
